// File: rtl/fsm_stream_pkg.sv
// Shared definitions for the serial FSM stream arbiter: controller states,
// default geometry and the requester-id width helper.
package fsm_stream_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer advances past the winner when the grant is taken.
module rr_arbiter
    import fsm_stream_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic            flux,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] ptr;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge flux or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en && any) begin
            ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

endmodule

// File: rtl/fsm_stream_arbiter.sv
// Shares one serial sequence FSM between NREQ requesters: arbitrate, stream
// the word LSB first, capture the FSM output per bit, return it tagged.
module fsm_stream_arbiter
    import fsm_stream_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                    flux,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    fsm_reset,
    output logic                    fsm_in,
    input  logic                    fsm_out,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [WIDTH-1:0]        resp_data
);

    localparam int CW = $clog2(WIDTH);

    ctrl_state_e     state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] word;
    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;
    logic            arb_any;
    logic            idle_open;
    logic            take;

    // Grants are suppressed while reset is held so gnt reads 0 immediately.
    assign idle_open = (state == ST_IDLE) && !reset;
    assign take      = idle_open && arb_any;
    assign gnt       = idle_open ? arb_gnt : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .flux   (flux),
        .reset  (reset),
        .req    (req),
        .en     (take),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    assign busy       = (state != ST_IDLE);
    assign fsm_reset  = !((state == ST_SHIFT) || (state == ST_DRAIN));
    assign fsm_in     = (state == ST_SHIFT) ? word[cnt] : 1'b0;
    assign resp_valid = (state == ST_DONE);

    always_ff @(posedge flux or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            word      <= '0;
            resp_id   <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        word    <= req_data[int'(arb_id)*WIDTH +: WIDTH];
                        resp_id <= arb_id;
                        cnt     <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The FSM's reaction to bit k-1 is visible during cycle k.
                    if (cnt != '0) resp_data[cnt - CW'(1)] <= fsm_out;
                    if (cnt == CW'(WIDTH - 1)) state <= ST_DRAIN;
                    else                       cnt   <= cnt + CW'(1);
                end
                ST_DRAIN: begin
                    resp_data[WIDTH-1] <= fsm_out;
                    state              <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
